// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch and data port) in
// front of one shared single-port memory. Grants are issued combinationally
// in IDLE; a read moves to RESP where the read data is returned one cycle
// later to the owner of the pending read. Writes complete in the grant cycle.
module mem_arbiter #(
  parameter bit RR_EN      = 1'b0,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction-fetch port (read only)
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  // shared memory
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  // statistics
  output logic [15:0] conflict_cnt
);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  // Streak counter only has to reach STARVE_MAX, so size it for that value.
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);

  state_t        state, state_nxt;
  owner_t        owner, owner_nxt;            // owner of the pending read
  owner_t        last_grant, last_grant_nxt;  // round-robin history
  logic [SW-1:0] streak, streak_nxt;          // consecutive data grants vs waiting fetch
  logic [15:0]   conflict_nxt;

  logic both;
  logic grant_f;
  logic grant_d;

  // Arbitration: decide which requester (if any) is granted this cycle.
  // Grants are suppressed while reset is held so every output reads 0.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    both    = if_req && d_req;
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (rst_n && (state == IDLE)) begin
      if (both) begin
        if (RR_EN) grant_d = (last_grant == OWN_FETCH);
        else       grant_d = (streak != STREAK_LIM);
        grant_f = !grant_d;
      end else begin
        grant_f = if_req;
        grant_d = d_req;
      end
    end
  end

  // FSM next state, handshakes and memory drive for the granted requester.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    if_ready  = 1'b0;
    d_ready   = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wmask = 4'h0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_f) begin
          if_ready  = 1'b1;
          mem_addr  = {if_addr[31:2], 2'b00};  // fetches are word aligned
          mem_ren   = 1'b1;
          owner_nxt = OWN_FETCH;
          state_nxt = RESP;
        end else if (grant_d) begin
          d_ready  = 1'b1;
          mem_addr = d_addr;
          if (d_we) begin
            // An all-zero mask is still a full write transaction.
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
            mem_wen   = 1'b1;
          end else begin
            mem_ren   = 1'b1;
            owner_nxt = OWN_DATA;
            state_nxt = RESP;
          end
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-data return: valid only in RESP for the pending read's owner.
  always_comb begin
    if_rvalid = (state == RESP) && (owner == OWN_FETCH);
    d_rvalid  = (state == RESP) && (owner == OWN_DATA);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
  end

  // Fairness bookkeeping: starvation streak, last grant, contention count.
  always_comb begin
    if (grant_f || !if_req)                      streak_nxt = '0;
    else if (grant_d && (streak != STREAK_LIM))  streak_nxt = streak + 1'b1;
    else                                         streak_nxt = streak;

    if (grant_f)      last_grant_nxt = OWN_FETCH;
    else if (grant_d) last_grant_nxt = OWN_DATA;
    else              last_grant_nxt = last_grant;

    if ((state == IDLE) && both && (conflict_cnt != 16'hFFFF))
      conflict_nxt = conflict_cnt + 16'd1;
    else
      conflict_nxt = conflict_cnt;
  end

  // State registers; reset drops any pending read and clears statistics.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= OWN_FETCH;
      last_grant   <= OWN_FETCH;
      streak       <= '0;
      conflict_cnt <= 16'h0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      last_grant   <= last_grant_nxt;
      streak       <= streak_nxt;
      conflict_cnt <= conflict_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Two instances share the stimulus:
// dut uses fixed priority with starvation guard, dut_rr uses round-robin.
// Inputs change on the falling edge and outputs are checked 1 ns later.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] mem_rdata;

  logic        if_ready, if_rvalid, d_ready, d_rvalid, mem_wen, mem_ren;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [15:0] conflict_cnt;

  logic        rr_if_ready, rr_if_rvalid, rr_d_ready, rr_d_rvalid, rr_mem_wen, rr_mem_ren;
  logic [31:0] rr_if_rdata, rr_d_rdata, rr_mem_addr, rr_mem_wdata;
  logic [3:0]  rr_mem_wmask;
  logic [15:0] rr_conflict_cnt;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.RR_EN(1'b0), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.RR_EN(1'b1), .STARVE_MAX(4)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(rr_if_ready),
    .if_rvalid(rr_if_rvalid), .if_rdata(rr_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ready(rr_d_ready), .d_rvalid(rr_d_rvalid), .d_rdata(rr_d_rdata),
    .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata), .mem_wmask(rr_mem_wmask),
    .mem_wen(rr_mem_wen), .mem_ren(rr_mem_ren), .mem_rdata(mem_rdata),
    .conflict_cnt(rr_conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    if_req  = 1'b0;
    if_addr = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    d_wmask = 4'h0;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_rdata = 32'h0;
    clr_inputs();

    // Reset held with both requesting: everything must stay at 0.
    #2;
    if_req = 1'b1; if_addr = 32'h10;
    d_req  = 1'b1; d_addr  = 32'h20;
    #1;
    chk("rst_if_ready",  32'(if_ready), 32'h0);
    chk("rst_d_ready",   32'(d_ready), 32'h0);
    chk("rst_mem_ren",   32'(mem_ren), 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_conflict",  32'(conflict_cnt), 32'h0);
    chk("rst_rr_dready", 32'(rr_d_ready), 32'h0);

    // Fetch-only, issued in the first cycle after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    clr_inputs();
    if_req = 1'b1; if_addr = 32'h0000_0006;
    #1;
    chk("A_if_ready",  32'(if_ready), 32'h1);
    chk("A_d_ready",   32'(d_ready), 32'h0);
    chk("A_mem_addr",  mem_addr, 32'h4);
    chk("A_mem_ren",   32'(mem_ren), 32'h1);
    chk("A_mem_wen",   32'(mem_wen), 32'h0);
    chk("A_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("A_if_rvalid", 32'(if_rvalid), 32'h0);
    @(negedge clk);
    if_req = 1'b0;
    mem_rdata = 32'h1234_5678;
    #1;
    chk("A_resp_if_rvalid", 32'(if_rvalid), 32'h1);
    chk("A_resp_if_rdata",  if_rdata, 32'h1234_5678);
    chk("A_resp_d_rvalid",  32'(d_rvalid), 32'h0);
    chk("A_resp_mem_ren",   32'(mem_ren), 32'h0);
    @(negedge clk);
    #1;
    chk("A_after_if_rvalid", 32'(if_rvalid), 32'h0);
    chk("A_after_if_rdata",  if_rdata, 32'h0);
    chk("A_after_mem_addr",  mem_addr, 32'h0);

    // Data write, full mask.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_wdata = 32'h2; d_wmask = 4'hF;
    #1;
    chk("B_d_ready",   32'(d_ready), 32'h1);
    chk("B_if_ready",  32'(if_ready), 32'h0);
    chk("B_mem_wen",   32'(mem_wen), 32'h1);
    chk("B_mem_ren",   32'(mem_ren), 32'h0);
    chk("B_mem_addr",  mem_addr, 32'h4);
    chk("B_mem_wdata", mem_wdata, 32'h2);
    chk("B_mem_wmask", 32'(mem_wmask), 32'hF);
    // Write with empty mask follows immediately: no RESP cycle after a write.
    @(negedge clk);
    d_wdata = 32'h55; d_wmask = 4'h0;
    #1;
    chk("B_next_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("B0_d_ready",      32'(d_ready), 32'h1);
    chk("B0_mem_wen",      32'(mem_wen), 32'h1);
    chk("B0_mem_wmask",    32'(mem_wmask), 32'h0);
    @(negedge clk);
    clr_inputs();
    #1;
    chk("B0_next_d_rvalid", 32'(d_rvalid), 32'h0);

    // Contention, data read at unaligned address. Fixed priority grants data;
    // round-robin last granted data (the writes) so it grants fetch.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h13;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h7;
    #1;
    chk("C_d_ready",     32'(d_ready), 32'h1);
    chk("C_if_ready",    32'(if_ready), 32'h0);
    chk("C_mem_addr",    mem_addr, 32'h7);
    chk("C_mem_ren",     32'(mem_ren), 32'h1);
    chk("C_rr_if_ready", 32'(rr_if_ready), 32'h1);
    chk("C_rr_d_ready",  32'(rr_d_ready), 32'h0);
    chk("C_rr_mem_addr", rr_mem_addr, 32'h10);
    @(negedge clk);
    clr_inputs();
    mem_rdata = 32'hABCD_0001;
    #1;
    chk("C_d_rvalid",     32'(d_rvalid), 32'h1);
    chk("C_d_rdata",      d_rdata, 32'hABCD_0001);
    chk("C_if_rvalid",    32'(if_rvalid), 32'h0);
    chk("C_rr_if_rvalid", 32'(rr_if_rvalid), 32'h1);
    chk("C_rr_if_rdata",  rr_if_rdata, 32'hABCD_0001);
    chk("C_conflict",     32'(conflict_cnt), 32'h1);
    chk("C_rr_conflict",  32'(rr_conflict_cnt), 32'h1);

    // Fetch request raised in RESP and dropped before IDLE is never granted.
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h30;
    #1;
    chk("F_d_ready", 32'(d_ready), 32'h1);
    @(negedge clk);
    d_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("F_resp_if_ready", 32'(if_ready), 32'h0);
    chk("F_resp_mem_ren",  32'(mem_ren), 32'h0);
    chk("F_resp_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    clr_inputs();
    #1;
    chk("F_idle_if_ready", 32'(if_ready), 32'h0);
    chk("F_idle_mem_ren",  32'(mem_ren), 32'h0);
    chk("F_idle_rvalid",   32'(if_rvalid), 32'h0);

    // Reset asserted while a data read is pending.
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h8;
    #1;
    chk("E_d_ready", 32'(d_ready), 32'h1);
    @(negedge clk);
    d_req = 1'b0;
    rst_n = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("E_d_rvalid",    32'(d_rvalid), 32'h0);
    chk("E_d_rdata",     d_rdata, 32'h0);
    chk("E_mem_ren",     32'(mem_ren), 32'h0);
    chk("E_conflict",    32'(conflict_cnt), 32'h0);
    chk("E_rr_conflict", 32'(rr_conflict_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("E_rel_d_rvalid",  32'(d_rvalid), 32'h0);
    chk("E_rel_if_rvalid", 32'(if_rvalid), 32'h0);

    // Continuous contention with data reads. Fixed priority: D D D D F repeat.
    // Round-robin from reset: D F D F ... Conflicts count only in IDLE cycles.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (i % 2 == 0) begin
        chk($sformatf("D_d_ready[%0d]", i),     32'(d_ready), 32'(((i / 2) % 5) != 4));
        chk($sformatf("D_if_ready[%0d]", i),    32'(if_ready), 32'(((i / 2) % 5) == 4));
        chk($sformatf("D_rr_d_ready[%0d]", i),  32'(rr_d_ready), 32'(((i / 2) % 2) == 0));
        chk($sformatf("D_rr_if_ready[%0d]", i), 32'(rr_if_ready), 32'(((i / 2) % 2) == 1));
        mem_rdata = 32'h5000_0000 + 32'(i + 1);
      end else begin
        chk($sformatf("D_resp_ready[%0d]", i), 32'({if_ready, d_ready}), 32'h0);
        chk($sformatf("D_d_rdata[%0d]", i), d_rdata,
            ((((i - 1) / 2) % 5) != 4) ? 32'h5000_0000 + 32'(i) : 32'h0);
        chk($sformatf("D_rr_if_rvalid[%0d]", i), 32'(rr_if_rvalid),
            32'((((i - 1) / 2) % 2) == 1));
      end
      chk($sformatf("D_conflict[%0d]", i),    32'(conflict_cnt), 32'((i + 1) / 2));
      chk($sformatf("D_rr_conflict[%0d]", i), 32'(rr_conflict_cnt), 32'((i + 1) / 2));
    end
    @(negedge clk);
    clr_inputs();
    #1;
    chk("D_final_conflict", 32'(conflict_cnt), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
